// File: rtl/oscope_pkg.sv
// Purpose : shared types and frame geometry for the serial-ADC loopback responder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package oscope_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } adc_tx_state_t;

   localparam int ADC_DATA_W    = 12;
   localparam int ADC_PAD_HI    = 2;
   localparam int ADC_PAD_LO    = 2;
   localparam int ADC_FRAME_LEN = ADC_PAD_HI + ADC_DATA_W + ADC_PAD_LO;

endpackage

// File: rtl/adc_frame_tx_if.sv
// Purpose : groups the ADC link pins, sample input and status outputs of adc_frame_tx.
// Latency : n/a (wires only).
// Backpressure: none; the capture side paces the link, sample_valid is a bare strobe.
// Ports   : master = stimulus side (drives conv/clk/sample), slave = responder.
interface adc_frame_tx_if
   import oscope_pkg::*;
#(
   parameter int DATA_W = ADC_DATA_W
);
   logic              adc_conv;
   logic              adc_clk;
   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              adc_data;
   logic              busy;
   logic              frame_done;
   logic              frame_abort;
   logic              stale;
   logic [15:0]       frame_count;

   modport master (
      output adc_conv, adc_clk, sample_valid, sample_data,
      input  adc_data, busy, frame_done, frame_abort, stale, frame_count
   );

   modport slave (
      input  adc_conv, adc_clk, sample_valid, sample_data,
      output adc_data, busy, frame_done, frame_abort, stale, frame_count
   );
endinterface

// File: rtl/sync_edge.sv
// Purpose : STAGES-deep synchronizer for an asynchronous pin plus rise/fall detect.
// Latency : level valid STAGES cycles after the pin; rise/fall are combinational on that level.
// Backpressure: none.
// Ports   : clk/rst_n, din (async pin), level (synchronized), rise/fall (1-cycle pulses).
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      // shift the pin in at bit 0; the cast drops the oldest bit
      sync_d = STAGES'({sync_q, din});
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~prev_q;
   assign fall  = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/adc_frame_tx.sv
// Purpose : emulates a serial ADC: shifts {PAD_HI zeros, sample, PAD_LO zeros} out MSB first per conversion.
// Latency : adc_data responds SYNC_STAGES+1 osc_clk cycles after an adc_conv/adc_clk pin edge.
// Backpressure: none; the capture side paces frames via adc_conv/adc_clk, sample_valid always accepted.
// Ports   : osc_clk, reset (async active-low), bus (adc_frame_tx_if.slave: link pins, sample, status).
module adc_frame_tx
   import oscope_pkg::*;
#(
   parameter int DATA_W      = ADC_DATA_W,
   parameter int PAD_HI      = ADC_PAD_HI,
   parameter int PAD_LO      = ADC_PAD_LO,
   parameter int SYNC_STAGES = 2
) (
   input  logic           osc_clk,
   input  logic           reset,
   adc_frame_tx_if.slave  bus
);
   localparam int FRAME_LEN = PAD_HI + DATA_W + PAD_LO;
   localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);

   logic conv_level, conv_rise, conv_fall;
   logic clk_level_unused, clk_rise, clk_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES)) u_conv_sync (
      .clk   (osc_clk),
      .rst_n (reset),
      .din   (bus.adc_conv),
      .level (conv_level),
      .rise  (conv_rise),
      .fall  (conv_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk   (osc_clk),
      .rst_n (reset),
      .din   (bus.adc_clk),
      .level (clk_level_unused),
      .rise  (clk_rise),
      .fall  (clk_fall_unused)
   );

   adc_tx_state_t        state_q, state_d;
   logic [DATA_W-1:0]    hold_q, hold_d;
   logic                 fresh_q, fresh_d;
   logic [FRAME_LEN-1:0] shreg_q, shreg_d;
   logic [4:0]           bit_cnt_q, bit_cnt_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 done_q, done_d;
   logic                 abort_q, abort_d;
   logic                 stale_q, stale_d;
   logic [FRAME_LEN-1:0] frame_w;
   logic                 last_edge;

   always_comb begin
      frame_w   = FRAME_LEN'(hold_q) << PAD_LO;
      last_edge = clk_rise && (bit_cnt_q == LAST_BIT);

      state_d       = state_q;
      hold_d        = hold_q;
      fresh_d       = fresh_q;
      shreg_d       = shreg_q;
      bit_cnt_d     = bit_cnt_q;
      frame_count_d = frame_count_q;
      done_d        = 1'b0;
      abort_d       = 1'b0;
      stale_d       = stale_q;

      // adc_data is shreg_q's MSB, so the register is zero outside SHIFT
      case (state_q)
         IDLE: begin
            // only a high conv level arms; a conv-low start after reset never fires
            if (conv_level) state_d = ARMED;
         end
         ARMED: begin
            if (conv_fall) begin
               state_d   = SHIFT;
               shreg_d   = frame_w;
               bit_cnt_d = '0;
               stale_d   = !fresh_q;
               fresh_d   = 1'b0;
            end
         end
         SHIFT: begin
            // the clock edge takes priority over a coincident conv_rise
            if (last_edge) begin
               shreg_d       = '0;
               bit_cnt_d     = bit_cnt_q + 5'd1;
               done_d        = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = conv_rise ? ARMED : DONE;
            end else if (conv_rise) begin
               shreg_d = '0;
               abort_d = 1'b1;
               state_d = ARMED;
            end else if (clk_rise) begin
               shreg_d   = shreg_q << 1;
               bit_cnt_d = bit_cnt_q + 5'd1;
            end
         end
         DONE: begin
            if (conv_rise) state_d = ARMED;
         end
         default: state_d = IDLE;
      endcase

      // a sample in the load cycle misses this frame but marks the next one fresh
      if (bus.sample_valid) begin
         hold_d  = bus.sample_data;
         fresh_d = 1'b1;
      end
   end

   always_ff @(posedge osc_clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         hold_q        <= '0;
         fresh_q       <= 1'b0;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         frame_count_q <= '0;
         done_q        <= 1'b0;
         abort_q       <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         fresh_q       <= fresh_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         frame_count_q <= frame_count_d;
         done_q        <= done_d;
         abort_q       <= abort_d;
         stale_q       <= stale_d;
      end
   end

   assign bus.adc_data    = shreg_q[FRAME_LEN-1];
   assign bus.busy        = (state_q == SHIFT);
   assign bus.frame_done  = done_q;
   assign bus.frame_abort = abort_q;
   assign bus.stale       = stale_q;
   assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_adc_frame_tx.sv
module tb_adc_frame_tx;
   import oscope_pkg::*;

   localparam int PH = 8;   // osc_clk cycles per adc_clk phase / conv settle

   logic osc_clk = 1'b0;
   logic reset   = 1'b0;
   always #5 osc_clk = ~osc_clk;

   adc_frame_tx_if #(.DATA_W(ADC_DATA_W)) bus ();

   adc_frame_tx #(
      .DATA_W      (ADC_DATA_W),
      .PAD_HI      (ADC_PAD_HI),
      .PAD_LO      (ADC_PAD_LO),
      .SYNC_STAGES (2)
   ) dut (
      .osc_clk (osc_clk),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] word;
      logic        stale;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          abort_cnt = 0;
   logic [11:0] m_hold  = '0;
   logic        m_fresh = 1'b0;
   logic [15:0] m_count = '0;

   always @(negedge osc_clk) begin
      if (bus.frame_done === 1'b1)  done_cnt++;
      if (bus.frame_abort === 1'b1) abort_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge osc_clk);
   endtask

   task automatic load_sample(input logic [11:0] v);
      bus.sample_valid = 1'b1;
      bus.sample_data  = v;
      cyc(1);
      bus.sample_valid = 1'b0;
      m_hold  = v;
      m_fresh = 1'b1;
   endtask

   // arm, drop conv, optionally strobe a sample exactly in the load cycle
   task automatic start_frame(input logic [11:0] ld, input bit ld_en);
      exp_t e;
      bus.adc_conv = 1'b1;
      cyc(PH);
      bus.adc_conv = 1'b0;
      e.word  = 16'(m_hold) << ADC_PAD_LO;
      e.stale = !m_fresh;
      sb.push_back(e);
      m_fresh = 1'b0;
      cyc(2);
      if (ld_en) begin
         load_sample(ld);
         cyc(PH - 3);
      end else begin
         cyc(PH);
      end
      check_eq("busy_after_load", 32'(bus.busy), 32'd1);
      check_eq("stale_after_load", 32'(bus.stale), 32'(e.stale));
   endtask

   task automatic clock_bits(input int n, input bit conv_on_last, output logic [15:0] cap);
      cap = '0;
      for (int i = 0; i < n; i++) begin
         cap = {cap[14:0], bus.adc_data};
         bus.adc_clk = 1'b1;
         if (conv_on_last && i == n - 1) bus.adc_conv = 1'b1;
         cyc(PH);
         bus.adc_clk = 1'b0;
         cyc(PH);
      end
   endtask

   task automatic finish_frame(input bit coincident);
      logic [15:0] cap;
      exp_t        e;
      int          d0, a0;
      d0 = done_cnt;
      a0 = abort_cnt;
      clock_bits(16, coincident, cap);
      e = sb.pop_front();
      check_eq("frame_word", 32'(cap), 32'(e.word));
      check_eq("done_pulses", 32'(done_cnt - d0), 32'd1);
      check_eq("abort_pulses", 32'(abort_cnt - a0), 32'd0);
      check_eq("frame_count", 32'(bus.frame_count), 32'(m_count + 16'd1));
      check_eq("data_idle", 32'(bus.adc_data), 32'd0);
      check_eq("busy_idle", 32'(bus.busy), 32'd0);
      m_count = m_count + 16'd1;
   endtask

   initial begin
      logic [15:0] cap;
      exp_t        e;
      int          d0, a0;

      bus.adc_conv     = 1'b0;
      bus.adc_clk      = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      cyc(2);

      check_eq("rst_data", 32'(bus.adc_data), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.frame_done), 32'd0);
      check_eq("rst_abort", 32'(bus.frame_abort), 32'd0);
      check_eq("rst_stale", 32'(bus.stale), 32'd0);
      check_eq("rst_count", 32'(bus.frame_count), 32'd0);

      // conv low through reset and release: clocks must not start anything
      clock_bits(20, 1'b0, cap);
      reset = 1'b1;
      cyc(2);
      clock_bits(20, 1'b0, cap);
      check_eq("idle_capture", 32'(cap), 32'd0);
      check_eq("idle_busy", 32'(bus.busy), 32'd0);
      check_eq("idle_pulses", 32'(done_cnt + abort_cnt), 32'd0);

      // full frame of 0xABC, then extra clocks in DONE are ignored
      load_sample(12'hABC);
      start_frame('0, 1'b0);
      finish_frame(1'b0);
      clock_bits(2, 1'b0, cap);
      check_eq("done_extra_clk", 32'(cap), 32'd0);
      check_eq("done_count_hold", 32'(bus.frame_count), 32'(m_count));

      // abort after 5 clock edges
      load_sample(12'h3C3);
      start_frame('0, 1'b0);
      d0 = done_cnt;
      a0 = abort_cnt;
      clock_bits(5, 1'b0, cap);
      bus.adc_conv = 1'b1;
      cyc(PH);
      e = sb.pop_front();
      check_eq("abort_bits", 32'(cap[4:0]), 32'(e.word[15:11]));
      check_eq("abort_pulses", 32'(abort_cnt - a0), 32'd1);
      check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
      check_eq("abort_count", 32'(bus.frame_count), 32'(m_count));
      check_eq("abort_data", 32'(bus.adc_data), 32'd0);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);

      // recovery frame, then repeat without new sample (stale)
      load_sample(12'h5A5);
      start_frame('0, 1'b0);
      finish_frame(1'b0);
      start_frame('0, 1'b0);
      finish_frame(1'b0);

      // conv rise coincident with the last clock edge, then back-to-back frame
      load_sample(12'h0F1);
      start_frame('0, 1'b0);
      finish_frame(1'b1);
      load_sample(12'h9E7);
      start_frame('0, 1'b0);
      finish_frame(1'b0);

      // reset mid-frame
      load_sample(12'h246);
      start_frame('0, 1'b0);
      clock_bits(8, 1'b0, cap);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_data", 32'(bus.adc_data), 32'd0);
      check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_eq("mid_rst_stale", 32'(bus.stale), 32'd0);
      check_eq("mid_rst_count", 32'(bus.frame_count), 32'd0);
      e = sb.pop_front();
      check_eq("mid_rst_bits", 32'(cap[7:0]), 32'(e.word[15:8]));
      m_hold  = '0;
      m_fresh = 1'b0;
      m_count = '0;
      cyc(2);
      reset = 1'b1;
      cyc(2);

      // sample in the load cycle: old value now, new value next frame
      load_sample(12'h777);
      start_frame(12'h123, 1'b1);
      finish_frame(1'b0);
      start_frame('0, 1'b0);
      finish_frame(1'b0);

      check_eq("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
